// File: rtl/sdfp_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module   : sdfp_cic_decimator
// Brief    : Third-order CIC decimator (R = 2**DEC_LOG2) for the SDFP stream.
//            Optional macro SDFP_CIC_GAIN_NORM_EN scales the output by R**-3.
// Revision : 1.0 - initial release
// ============================================================================
module sdfp_cic_decimator #(
    parameter int BW       = 24,
    parameter int IN_BW    = 4,
    parameter int DEC_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [IN_BW-1:0] in_data,
    output logic             out_valid,
    output logic [BW-1:0]    out_data
);

    localparam logic [DEC_LOG2-1:0] c_cnt_last = '1;
    localparam int                  c_shift    = 3 * DEC_LOG2;

    generate
        if (DEC_LOG2 < 1 || DEC_LOG2 > 8 || IN_BW + 3 * DEC_LOG2 > BW) begin : g_param_check
            $error("sdfp_cic_decimator: illegal DEC_LOG2/IN_BW/BW combination");
        end
    endgenerate

    logic [BW-1:0]       i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
    logic [BW-1:0]       d1_q, d2_q, d3_q, d1_d, d2_d, d3_d;
    logic [DEC_LOG2-1:0] cnt_q, cnt_d;
    logic [BW-1:0]       out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;

    logic [BW-1:0] w_x;
    logic [BW-1:0] w_i1_sum, w_i2_sum, w_i3_sum;
    logic [BW-1:0] w_c1, w_c2, w_c3, w_c3_out;

    always_comb begin
        w_x      = {{(BW - IN_BW){in_data[IN_BW-1]}}, in_data};
        // Integrator cascade and comb chain settle within one cycle; all modulo 2**BW.
        w_i1_sum = i1_q + w_x;
        w_i2_sum = i2_q + w_i1_sum;
        w_i3_sum = i3_q + w_i2_sum;
        w_c1     = w_i3_sum - d1_q;
        w_c2     = w_c1 - d2_q;
        w_c3     = w_c2 - d3_q;
`ifdef SDFP_CIC_GAIN_NORM_EN
        w_c3_out = $signed(w_c3) >>> c_shift;
`else
        w_c3_out = w_c3;
`endif
    end

    always_comb begin
        i1_d        = i1_q;
        i2_d        = i2_q;
        i3_d        = i3_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        d3_d        = d3_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            i1_d  = w_i1_sum;
            i2_d  = w_i2_sum;
            i3_d  = w_i3_sum;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == c_cnt_last) begin
                d1_d        = w_i3_sum;
                d2_d        = w_c1;
                d3_d        = w_c2;
                out_data_d  = w_c3_out;
                out_valid_d = 1'b1;
            end
        end
    end

    // clr is a full datapath re-sync and therefore shares the reset branch.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            i1_q        <= '0;
            i2_q        <= '0;
            i3_q        <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            d3_q        <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            i3_q        <= i3_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            d3_q        <= d3_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sdfp_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdfp_cic_decimator
// Brief    : Self-checking bench; reference is a direct 10-tap FIR convolution
//            sampled every R-th accepted input. Honours SDFP_CIC_GAIN_NORM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdfp_cic_decimator;

    localparam int BW       = 24;
    localparam int IN_BW    = 4;
    localparam int DEC_LOG2 = 2;
    localparam int R        = 1 << DEC_LOG2;
    localparam int NTAP     = 10;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    clr = 1'b0;
    logic                    in_valid = 1'b0;
    logic [IN_BW-1:0]        in_data = '0;
    logic                    out_valid;
    logic signed [BW-1:0]    out_data;

    always #5 clk = ~clk;

    sdfp_cic_decimator #(
        .BW       (BW),
        .IN_BW    (IN_BW),
        .DEC_LOG2 (DEC_LOG2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    typedef struct {
        logic signed [BW-1:0] data;
        int                   due;
    } exp_t;

    typedef struct {
        string name;
        int    amp;
        int    gap;
        bit    impulse;
        int    e0;
        int    e1;
        int    e2;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   negs   = 0;
    int   phase  = 0;
    int   h [NTAP] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
    int   hist [NTAP];
    exp_t sbq [$];
    logic signed [BW-1:0] cap [$];
    vec_t tbl [7];

    function automatic logic signed [BW-1:0] scale(input longint v);
        logic signed [BW-1:0] r;
        r = v[BW-1:0];
`ifdef SDFP_CIC_GAIN_NORM_EN
        r = r >>> (3 * DEC_LOG2);
`endif
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: y[n] = sum h[j]*x[n-j], taken on every R-th accepted sample.
    task automatic model(input bit r, input bit c, input bit v, input int d);
        exp_t   e;
        longint acc;
        if (r || c) begin
            foreach (hist[i]) hist[i] = 0;
            phase = 0;
        end else if (v) begin
            for (int i = NTAP - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = d;
            if (phase == R - 1) begin
                acc = 0;
                for (int j = 0; j < NTAP; j++) acc += longint'(h[j]) * longint'(hist[j]);
                e.data = scale(acc);
                e.due  = negs + 1;
                sbq.push_back(e);
                phase = 0;
            end else begin
                phase++;
            end
        end
    endtask

    task automatic step(input bit r, input bit c, input bit v, input int d);
        logic [31:0] dv;
        dv       = d;
        rst      = r;
        clr      = c;
        in_valid = v;
        in_data  = dv[IN_BW-1:0];
        @(posedge clk);
        model(r, c, v, d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, int'($urandom_range(15)) - 8);
    endtask

    task automatic check_three(input string name, input int e0, input int e1, input int e2);
        check({name, "_count"}, cap.size(), 3);
        if (cap.size() >= 3) begin
            check({name, "_out0"}, cap[0], scale(e0));
            check({name, "_out1"}, cap[1], scale(e1));
            check({name, "_out2"}, cap[2], scale(e2));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        negs = negs + 1;
        if (out_valid) begin
            cap.push_back(out_data);
            if (sbq.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("sb_out_data", out_data, e.data);
                check("sb_pulse_cycle", negs, e.due);
            end
        end else if (sbq.size() != 0 && sbq[0].due <= negs) begin
            e = sbq.pop_front();
            check("sb_missed_pulse", 0, 1);
        end
    end

    task automatic mid_clear(input bit use_rst, input int pre);
        string nm;
        nm = $sformatf("%s_after_%0d", use_rst ? "rst" : "clr", pre);
        step(1, 0, 0, 0);
        for (int k = 0; k < pre; k++) step(0, 0, 1, 1);
        cap.delete();
        step(use_rst, !use_rst, 1, 1);
        check({nm, "_valid_low"}, out_valid, 0);
        check({nm, "_data_zero"}, out_data, 0);
        for (int k = 0; k < 3 * R; k++) step(0, 0, 1, 1);
        idle(2);
        check_three(nm, 20, 60, 64);
    endtask

    initial begin
        // Decimation samples the filter at one phase: an impulse at phase 0
        // lands on taps h[3] and h[7] of consecutive output frames.
        tbl[0] = '{"step_p1",    1, 0, 1'b0,   20,   60,   64};
        tbl[1] = '{"gap_p1",     1, 2, 1'b0,   20,   60,   64};
        tbl[2] = '{"step_m1",   -1, 0, 1'b0,  -20,  -60,  -64};
        tbl[3] = '{"step_p7",    7, 1, 1'b0,  140,  420,  448};
        tbl[4] = '{"step_m8",   -8, 0, 1'b0, -160, -480, -512};
        tbl[5] = '{"impulse_p1", 1, 0, 1'b1,   10,    6,    0};
        tbl[6] = '{"impulse_m8",-8, 3, 1'b1,  -80,  -48,    0};
        foreach (hist[i]) hist[i] = 0;

        step(1, 0, 1, 1);
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);

        foreach (tbl[t]) begin
            step(1, 0, 0, 0);
            cap.delete();
            for (int k = 0; k < 3 * R; k++) begin
                step(0, 0, 1, (tbl[t].impulse && k != 0) ? 0 : tbl[t].amp);
                for (int g = 0; g < tbl[t].gap; g++) step(0, 0, 0, int'($urandom_range(15)) - 8);
            end
            idle(3);
            check_three(tbl[t].name, tbl[t].e0, tbl[t].e1, tbl[t].e2);
            check({tbl[t].name, "_hold"}, out_data, scale(tbl[t].e2));
        end

        mid_clear(1'b0, 2);
        mid_clear(1'b1, 2);
        mid_clear(1'b0, R - 1);
        mid_clear(1'b1, R - 1);

        step(1, 0, 0, 0);
        cap.delete();
        for (int k = 0; k < 20000; k++) step(0, 0, 1, -8);
        idle(2);
        check("wrap_count", cap.size(), 20000 / R);
        if (cap.size() > 0) check("wrap_last", cap[cap.size()-1], scale(-512));

        idle(4);
        check("sb_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
